// File: rtl/e2prom_rw_test_if.sv
// I2C byte-driver bus between the E2PROM test sequencer
// (master) and the I2C byte driver (slave).
interface e2prom_rw_test_if;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (
    output i2c_exec,
    output i2c_rh_wl,
    output i2c_addr,
    output i2c_data_w,
    input  i2c_data_r,
    input  i2c_done,
    input  i2c_ack
  );

  modport slave (
    input  i2c_exec,
    input  i2c_rh_wl,
    input  i2c_addr,
    input  i2c_data_w,
    output i2c_data_r,
    output i2c_done,
    output i2c_ack
  );
endinterface

// File: rtl/e2prom_rw_test.sv
// Self-starting E2PROM write/read-back test: writes a[7:0]
// to each address, reads all back, reports pass/fail once.
module e2prom_rw_test #(
  parameter logic [19:0] WR_WAIT  = 20'd250_000,
  parameter logic [15:0] MAX_BYTE = 16'd256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  e2prom_rw_test_if.master         i2c,
  output logic                     rw_done,
  output logic                     rw_result
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_WR_REQ,
    S_WR_BUSY,
    S_RD_WAIT,
    S_RD_REQ,
    S_RD_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt;
  logic [15:0] r_addr;
  logic [15:0] w_addr;
  logic [7:0]  r_data_w;
  logic [7:0]  w_data_w;
  logic        r_err;
  logic        w_err;
  logic        r_rh_wl;
  logic        w_rh_wl;
  logic        r_exec;
  logic        w_exec;
  logic        r_done;
  logic        w_done;
  logic        r_result;
  logic        w_result;
  logic        w_last;
  logic        w_wait_end;

  assign w_last     = (r_addr == MAX_BYTE - 16'd1);
  assign w_wait_end = (r_cnt == WR_WAIT - 20'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_WAIT;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data_w <= '0;
      r_err    <= 1'b0;
      r_rh_wl  <= 1'b0;
      r_exec   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt;
      r_addr   <= w_addr;
      r_data_w <= w_data_w;
      r_err    <= w_err;
      r_rh_wl  <= w_rh_wl;
      r_exec   <= w_exec;
      r_done   <= w_done;
      r_result <= w_result;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    w_cnt    = r_cnt;
    w_addr   = r_addr;
    w_data_w = r_data_w;
    w_err    = r_err;
    w_rh_wl  = r_rh_wl;
    w_result = r_result;
    unique case (r_state)
      S_WAIT: begin
        if (w_wait_end) begin
          w_cnt    = '0;
          w_nxt    = S_WR_REQ;
          w_data_w = r_addr[7:0];
        end else begin
          w_cnt = r_cnt + 20'd1;
        end
      end
      S_WR_REQ: w_nxt = S_WR_BUSY;
      S_WR_BUSY: begin
        if (i2c.i2c_done) begin
          if (i2c.i2c_ack) begin
            w_err = 1'b1;
            w_nxt = S_DONE;
          end else if (w_last) begin
            w_addr  = '0;
            w_rh_wl = 1'b1;
            w_nxt   = S_RD_WAIT;
          end else begin
            w_addr = r_addr + 16'd1;
            w_nxt  = S_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (w_wait_end) begin
          w_cnt = '0;
          w_nxt = S_RD_REQ;
        end else begin
          w_cnt = r_cnt + 20'd1;
        end
      end
      S_RD_REQ: w_nxt = S_RD_BUSY;
      S_RD_BUSY: begin
        if (i2c.i2c_done) begin
          if (i2c.i2c_ack) begin
            w_err = 1'b1;
            w_nxt = S_DONE;
          end else begin
            // data mismatch is recorded but reading continues
            if (i2c.i2c_data_r != r_addr[7:0])
              w_err = 1'b1;
            if (w_last) begin
              w_nxt = S_DONE;
            end else begin
              w_addr = r_addr + 16'd1;
              w_nxt  = S_RD_REQ;
            end
          end
        end
      end
      S_DONE: w_nxt = S_DONE;
      default: w_nxt = S_WAIT;
    endcase
    w_exec = (w_nxt == S_WR_REQ) || (w_nxt == S_RD_REQ);
    w_done = (w_nxt == S_DONE) && (r_state != S_DONE);
    if (w_done)
      w_result = ~w_err;
  end

  assign i2c.i2c_exec   = r_exec;
  assign i2c.i2c_rh_wl  = r_rh_wl;
  assign i2c.i2c_addr   = r_addr;
  assign i2c.i2c_data_w = r_data_w;
  assign rw_done        = r_done;
  assign rw_result      = r_result;

endmodule

// File: doc/e2prom_rw_test.md
Name: e2prom_rw_test

Overview:
- Self-starting E2PROM write/read-back test sequencer that sits between the I2C byte driver and the LED alarm block.
- After reset it writes a known pattern to MAX_BYTE consecutive addresses through the I2C driver, then reads every address back and compares.
- It reports the outcome on rw_done (pulse) and rw_result (level), which feed the alarm LED logic.

Parameters:
- WR_WAIT, default 20'd250_000: clk cycles idled before each write (E2PROM internal write time, 5 ms at 50 MHz); also used as the power-up delay.
- MAX_BYTE, default 16'd256: number of bytes tested, covering addresses 0..MAX_BYTE-1; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i2c_exec  output  1  one-cycle start pulse for one I2C byte transfer
- i2c_rh_wl  output  1  transfer type: 1 = read, 0 = write; held stable from i2c_exec until i2c_done
- i2c_addr  output  16  E2PROM byte address
- i2c_data_w  output  8  write data
- i2c_data_r  input  8  read data; valid in the cycle i2c_done is high
- i2c_done  input  1  one-cycle pulse marking the end of the current transfer
- i2c_ack  input  1  sampled with i2c_done: 0 = slave acked, 1 = NACK/error
- rw_done  output  1  one-cycle pulse when the test finishes
- rw_result  output  1  test result: 1 = pass, 0 = fail; valid from rw_done onward

Behaviour:
- Reset values: i2c_exec=0, i2c_rh_wl=0, i2c_addr=0, i2c_data_w=0, rw_done=0, rw_result=0, state=S_WAIT, wait counter=0, err flag=0.
- Write pattern: each address a is written with a[7:0]. Read-back expects the same value.
- S_WAIT:
  - Counts 0..WR_WAIT-1.
  - On the count reaching WR_WAIT-1: clear the counter and go to S_WR_REQ.
- S_WR_REQ:
  - For exactly one cycle drive i2c_exec=1, i2c_rh_wl=0, and i2c_data_w=i2c_addr[7:0].
  - Next state is S_WR_BUSY.
- S_WR_BUSY: wait for i2c_done.
  - i2c_ack=1: set err and go to S_DONE (abort).
  - Else, if i2c_addr==MAX_BYTE-1: set i2c_addr=0 and go to S_RD_WAIT.
  - Else: increment i2c_addr and go to S_WAIT.
- S_RD_WAIT:
  - One WR_WAIT delay, so the last write completes.
  - Then go to S_RD_REQ.
- S_RD_REQ:
  - For one cycle drive i2c_exec=1 and i2c_rh_wl=1.
  - Next state is S_RD_BUSY.
- S_RD_BUSY: on i2c_done:
  - i2c_ack=1: set err and go to S_DONE.
  - Else, if i2c_data_r != i2c_addr[7:0]: set err. Continue reading; do not abort on a data mismatch.
  - Then, if i2c_addr==MAX_BYTE-1: go to S_DONE.
  - Else: increment i2c_addr and go to S_RD_REQ. The next i2c_exec follows i2c_done with exactly 1 idle cycle (the S_RD_REQ entry).
- S_DONE:
  - On the entry cycle assert rw_done=1 for exactly one cycle and register rw_result=~err (the err value including the final compare).
  - Then remain in S_DONE forever. The test runs once per reset; rw_result holds and i2c_exec stays 0.
- Other events:
  - i2c_done outside the BUSY states is ignored.
  - i2c_exec is never high in two consecutive cycles.
  - i2c_rh_wl and i2c_addr change only on state transitions out of the BUSY states.
- Reset mid-operation: all state and outputs return to their reset values immediately (asynchronous); the test restarts from address 0 after the power-up delay.
- Widths:
  - The wait counter is 20 bits.
  - Address comparisons use the 16-bit MAX_BYTE-1.
  - MAX_BYTE=1 gives a single write followed by a single read.

Test Plan (WR_WAIT=10, MAX_BYTE=4 unless stated):
- Ideal I2C model (acks, returns stored data, i2c_done 5 cycles after exec):
  - First i2c_exec occurs 11 cycles after reset release.
  - 4 writes at addresses 0..3 carry data 00..03, with ≥10 idle cycles between a write's done and the next exec.
  - 4 reads follow.
  - rw_done pulses once, rw_result=1, and no further i2c_exec occurs.
- Model corrupts address 2 on read (returns 0x55): all 4 reads are still issued; rw_done pulses once with rw_result=0.
- Model returns i2c_ack=1 on the 2nd write: no further i2c_exec occurs; rw_done pulses on the next cycle; rw_result=0.
- Model returns i2c_ack=1 on the last read with correct data: rw_result=0.
- Assert rst_n low during the 3rd read, release after 3 cycles:
  - Outputs are at reset values while reset is low.
  - The sequence restarts at address 0 with writes.
  - A clean run then ends with rw_result=1.
- MAX_BYTE=1 with a spurious i2c_done injected during S_WAIT:
  - The spurious pulse is ignored.
  - Exactly 1 write and 1 read occur, both at address 0.
  - rw_result=1.
